seq_divider_4bit: RTL and testbench
===================================

SEQ_DIVIDER_4BIT -- requirements
Module: seq_divider_4bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have no parameters; operand width is fixed at 4 bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 dividend  input  4  unsigned dividend, sampled at the accepting edge.
REQ-007 divisor  input  4  unsigned divisor, sampled at the accepting edge.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; results are valid while it is high.
REQ-010 quotient  output  4  registered quotient.
REQ-011 remainder  output  4  registered remainder.
REQ-012 div_by_zero  output  1  registered flag, meaningful while done is high.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE transitions:
- start=1 at edge E0 loads dividend, divisor and a 4-bit partial remainder of 0.
- The iteration counter is cleared and the state becomes RUN.
- start=0 keeps the state in IDLE.
REQ-015 Each RUN edge SHALL perform one restoring step:
- shift {partial_rem, dividend_reg} left by 1;
- compute a 5-bit trial value = {0,partial_rem} - {0,divisor}.
REQ-016 If the trial MSB is 0, partial_rem SHALL take the trial[3:0] value and the quotient LSB SHALL be 1; otherwise partial_rem SHALL be restored and the quotient LSB SHALL be 0.
REQ-017 Iteration count and completion:
- exactly 4 RUN edges (E1..E4) SHALL occur;
- at E4, quotient and remainder SHALL be updated and the state SHALL become DONE.
REQ-018 DONE SHALL assert done=1 for exactly one cycle and return to IDLE on the next edge, unconditionally.
REQ-019 Latency:
- done SHALL be high in the cycle after E4, i.e. 5 edges after the accepting edge;
- the next start SHALL be accepted no earlier than the edge that leaves DONE.
REQ-020 start SHALL be ignored in RUN and DONE; input changes during RUN SHALL NOT affect the result.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values until the next completion.
REQ-022 For every divisor != 0, results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-023 rst_n=0 SHALL immediately force:
- state to IDLE;
- busy=0, done=0;
- quotient=0, remainder=0, div_by_zero=0;
- all internal registers to 0.
REQ-024 A reset in RUN or DONE SHALL abort the operation; no done pulse SHALL follow it.
REQ-025 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro DIV_ZERO_DETECT_EN controls divide-by-zero handling.
REQ-027 With DIV_ZERO_DETECT_EN defined, a divisor of 0 at the accepting edge SHALL:
- skip RUN and go directly to DONE;
- load quotient=4'hF, remainder=dividend, div_by_zero=1;
- give done high in the cycle after E0.
REQ-028 With DIV_ZERO_DETECT_EN defined, any completion with divisor != 0 SHALL give div_by_zero=0.
REQ-029 Without DIV_ZERO_DETECT_EN:
- divisor 0 SHALL run the normal 4-step sequence, giving quotient=4'hF and remainder=dividend;
- div_by_zero SHALL be tied to 0.

Verification
REQ-030 Dividend 13, divisor 3, start pulse -> done 5 edges later; quotient=4, remainder=1, busy high for 5 cycles.
REQ-031 15/1 -> quotient=15, remainder=0. Then 2/7 -> quotient=0, remainder=2, issued back-to-back at the earliest allowed edge.
REQ-032 Dividend 9, divisor 0:
- with DIV_ZERO_DETECT_EN -> done after 1 edge, quotient=15, remainder=9, div_by_zero=1;
- without it -> done after 5 edges, div_by_zero=0.
REQ-033 Start 13/3, then start=1 with 6/2 in every RUN cycle -> single result quotient=4, remainder=1; no extra done.
REQ-034 rst_n pulsed low after E2 of 13/3 -> outputs 0 immediately, no done; a following 6/2 -> quotient=3, remainder=0.
REQ-035 Exhaustive sweep of all 256 operand pairs -> every result matches the reference model for REQ-022 and REQ-027/029.

Source files
------------

// File: rtl/seq_divider_4bit.sv
// 4-bit unsigned restoring divider: one quotient bit per RUN cycle, one-cycle done pulse.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor skips RUN and flags div_by_zero.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | four restoring steps, quotient bits shift into dividend_reg
// DONE  | done pulse for one cycle, then back to IDLE unconditionally
module seq_divider_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [3:0] dividend_reg;
  logic [3:0] divisor_reg;
  logic [3:0] partial_rem;
  logic [1:0] iter_cnt;

  logic [7:0] shift_pair;
  logic [4:0] trial;
  logic [3:0] rem_nxt;
  logic [3:0] quo_nxt;
  logic       accept;
  logic       last_step;
  logic       zero_skip;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (iter_cnt == 2'd3);

`ifdef DIV_ZERO_DETECT_EN
  assign zero_skip = (divisor == 4'd0);
`else
  assign zero_skip = 1'b0;
`endif

  // The bit shifted out of partial_rem is always 0: after k steps it is < 2^k.
  always_comb begin
    shift_pair = {partial_rem, dividend_reg} << 1;
    trial      = {1'b0, shift_pair[7:4]} - {1'b0, divisor_reg};
    rem_nxt    = trial[4] ? shift_pair[7:4] : trial[3:0];
    quo_nxt    = shift_pair[3:0] | {3'b000, ~trial[4]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = zero_skip ? DONE : RUN;
        end
      end
      RUN: begin
        if (iter_cnt == 2'd3) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_reg <= 4'd0;
      divisor_reg  <= 4'd0;
      partial_rem  <= 4'd0;
      iter_cnt     <= 2'd0;
      quotient     <= 4'd0;
      remainder    <= 4'd0;
    end else if (accept) begin
      dividend_reg <= dividend;
      divisor_reg  <= divisor;
      partial_rem  <= 4'd0;
      iter_cnt     <= 2'd0;
      if (zero_skip) begin
        quotient  <= 4'hF;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      dividend_reg <= quo_nxt;
      partial_rem  <= rem_nxt;
      iter_cnt     <= iter_cnt + 2'd1;
      if (last_step) begin
        quotient  <= quo_nxt;
        remainder <= rem_nxt;
      end
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
    end else if (accept && zero_skip) begin
      dbz_q <= 1'b1;
    end else if (last_step) begin
      dbz_q <= 1'b0;
    end
  end

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider_4bit.sv
// Directed self-checking bench for seq_divider_4bit; expected values are hand-derived
// or come from a plain a/b, a%b reference in the sweep.
module tb_seq_divider_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider_4bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is accepted on the next posedge. Operands are
  // scrambled during RUN so any late sampling shows up in the result.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         output int lat, output int bcyc,
                         output logic [3:0] q, output logic [3:0] r, output logic z);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + 4'd5;
    lat  = 1;
    bcyc = 0;
    while (!done && lat < 20) begin
      bcyc += int'(busy);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bcyc += int'(busy);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    check_eq("done_seen", 16'(done), 16'd1);
    @(posedge clk);
    @(negedge clk);
    check_eq("done_one_cycle", 16'(done), 16'd0);
    check_eq("idle_after_done", 16'(busy), 16'd0);
  endtask

  int         lat;
  int         bcyc;
  int         extra_done;
  logic [3:0] q;
  logic [3:0] r;
  logic       z;
  logic [3:0] exp_q;
  logic [3:0] exp_r;
  logic       exp_z;
  int         exp_lat;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    #3;
    check_eq("rst_busy", 16'(busy), 16'd0);
    check_eq("rst_done", 16'(done), 16'd0);
    check_eq("rst_quotient", 16'(quotient), 16'd0);
    check_eq("rst_remainder", 16'(remainder), 16'd0);
    check_eq("rst_dbz", 16'(div_by_zero), 16'd0);

    // 13/3 on the very first edge after reset release
    @(negedge clk);
    rst_n = 1'b1;
    run_div(4'd13, 4'd3, lat, bcyc, q, r, z);
    check_eq("13/3 latency", 16'(lat), 16'd5);
    check_eq("13/3 busy_cycles", 16'(bcyc), 16'd5);
    check_eq("13/3 quotient", 16'(q), 16'd4);
    check_eq("13/3 remainder", 16'(r), 16'd1);
    check_eq("13/3 dbz", 16'(z), 16'd0);
    check_eq("13/3 hold_q", 16'(quotient), 16'd4);

    // 15/1 then 2/7 at the earliest acceptable edge
    run_div(4'd15, 4'd1, lat, bcyc, q, r, z);
    check_eq("15/1 quotient", 16'(q), 16'd15);
    check_eq("15/1 remainder", 16'(r), 16'd0);
    run_div(4'd2, 4'd7, lat, bcyc, q, r, z);
    check_eq("2/7 quotient", 16'(q), 16'd0);
    check_eq("2/7 remainder", 16'(r), 16'd2);
    check_eq("2/7 latency", 16'(lat), 16'd5);

    // 9/0
    run_div(4'd9, 4'd0, lat, bcyc, q, r, z);
    check_eq("9/0 quotient", 16'(q), 16'd15);
    check_eq("9/0 remainder", 16'(r), 16'd9);
`ifdef DIV_ZERO_DETECT_EN
    check_eq("9/0 latency", 16'(lat), 16'd1);
    check_eq("9/0 dbz", 16'(z), 16'd1);
`else
    check_eq("9/0 latency", 16'(lat), 16'd5);
    check_eq("9/0 dbz", 16'(z), 16'd0);
`endif

    // 13/3 with start held high and 6/2 presented through RUN
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd6;
    divisor  = 4'd2;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("hold_start latency", 16'(lat), 16'd5);
    check_eq("hold_start quotient", 16'(quotient), 16'd4);
    check_eq("hold_start remainder", 16'(remainder), 16'd1);
    @(posedge clk);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      extra_done += int'(done);
    end
    check_eq("hold_start extra_done", 16'(extra_done), 16'd0);

    // reset after E2 of 13/3
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort busy", 16'(busy), 16'd0);
    check_eq("abort done", 16'(done), 16'd0);
    check_eq("abort quotient", 16'(quotient), 16'd0);
    check_eq("abort remainder", 16'(remainder), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      extra_done += int'(done);
    end
    check_eq("abort no_done", 16'(extra_done), 16'd0);
    run_div(4'd6, 4'd2, lat, bcyc, q, r, z);
    check_eq("6/2 quotient", 16'(q), 16'd3);
    check_eq("6/2 remainder", 16'(r), 16'd0);

    // all operand pairs
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(4'(a), 4'(b), lat, bcyc, q, r, z);
        if (b == 0) begin
          exp_q = 4'hF;
          exp_r = 4'(a);
`ifdef DIV_ZERO_DETECT_EN
          exp_z   = 1'b1;
          exp_lat = 1;
`else
          exp_z   = 1'b0;
          exp_lat = 5;
`endif
        end else begin
          exp_q   = 4'(a / b);
          exp_r   = 4'(a % b);
          exp_z   = 1'b0;
          exp_lat = 5;
        end
        check_eq($sformatf("sweep %0d/%0d {lat,q,r,dbz}", a, b),
                 {4'(lat), q, r, 3'b000, z},
                 {4'(exp_lat), exp_q, exp_r, 3'b000, exp_z});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
